// File: rtl/bean_ctrl_pkg.sv
// Shared control encodings for the BEAN-1 core.
// Used by control_unit, alu_decoder and datapath.
package bean_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_LOAD_WB,
    ST_HALT
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] REG_SEL_MEM = 2'b00;
  localparam logic [1:0] REG_SEL_ALU = 2'b01;
  localparam logic [1:0] REG_SEL_PC4 = 2'b10;
  localparam logic [1:0] REG_SEL_IMM = 2'b11;

  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_TGT  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_I    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  localparam logic [2:0] MEM_W  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_B  = 3'b010;
  localparam logic [2:0] MEM_HU = 3'b101;
  localparam logic [2:0] MEM_BU = 3'b110;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  typedef struct packed {
    logic       reg_we;
    logic       rs1_sel;
    logic       rs2_sel;
    logic       addrs_sel;
    logic       pc_en;
    logic       instr_en;
    logic       alu_mem_en;
    logic       mem_in_en;
    logic       mem_we;
    logic [1:0] reg_sel;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [2:0] mem_mode;
    logic [3:0] alu_mode;
  } ctrl_t;

  function automatic logic [2:0] mem_mode_of(
    input logic [2:0] f3
  );
    logic [2:0] m;
    m = MEM_W;
    unique case (f3)
      3'b000:  m = MEM_B;
      3'b001:  m = MEM_H;
      3'b100:  m = MEM_BU;
      3'b101:  m = MEM_HU;
      default: m = MEM_W;
    endcase
    return m;
  endfunction

  function automatic logic insn_legal(
    input logic [6:0] opc,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    logic ok;
    ok = 1'b0;
    unique case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL:
        ok = 1'b1;
      OPC_JALR:
        ok = (f3 == 3'b000);
      OPC_BRANCH:
        ok = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:
        ok = (f3 != 3'b011) && (f3 != 3'b110)
          && (f3 != 3'b111);
      OPC_STORE:
        ok = (f3 == 3'b000) || (f3 == 3'b001)
          || (f3 == 3'b010);
      OPC_OP_IMM: begin
        if (f3 == 3'b001)
          ok = (f7 == 7'h00);
        else if (f3 == 3'b101)
          ok = (f7 == 7'h00) || (f7 == 7'h20);
        else
          ok = 1'b1;
      end
      OPC_OP:
        ok = (f7 == 7'h00) || ((f7 == 7'h20)
          && ((f3 == 3'b000) || (f3 == 3'b101)));
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU operation decode from opcode/funct3/instr[30].
// Non-arithmetic opcodes use ADD for address math.
module alu_decoder
  import bean_ctrl_pkg::*;
(
  input  logic [6:0] opc,
  input  logic [2:0] funct3,
  input  logic       alt,
  output logic [3:0] alu_mode
);

  // map funct3 to ALU op; SUB only for register OP
  always_comb begin
    alu_mode = ALU_ADD;
    if ((opc == OPC_OP) || (opc == OPC_OP_IMM)) begin
      unique case (funct3)
        3'b000: alu_mode =
          ((opc == OPC_OP) && alt) ? ALU_SUB : ALU_ADD;
        3'b001: alu_mode = ALU_SLL;
        3'b010: alu_mode = ALU_SLT;
        3'b011: alu_mode = ALU_SLTU;
        3'b100: alu_mode = ALU_XOR;
        3'b101: alu_mode = alt ? ALU_SRA : ALU_SRL;
        3'b110: alu_mode = ALU_OR;
        3'b111: alu_mode = ALU_AND;
        default: alu_mode = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: FETCH -> EXEC (-> LOAD_WB).
// Halts on illegal/system opcodes, counts retirements.
module control_unit
  import bean_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             br_EQ,
  input  logic             br_LT,
  input  logic             br_LTU,
  output logic             reg_WE,
  output logic             rs1_SEL,
  output logic             rs2_SEL,
  output logic             addrs_SEL,
  output logic             pc_EN,
  output logic             instr_EN,
  output logic             ALU_mem_EN,
  output logic             mem_in_EN,
  output logic             mem_WE,
  output logic [1:0]       reg_SEL,
  output logic [1:0]       pc_SEL,
  output logic [2:0]       imm_SEL,
  output logic [2:0]       mem_MODE,
  output logic [3:0]       ALU_MODE,
  output logic             halted,
  output logic [CNT_W-1:0] retire_CNT
);

  state_t     state;
  state_t     state_nx;
  ctrl_t      c;
  ctrl_t      o;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [3:0] alu_mode;
  logic       legal;
  logic       taken;
  logic       unused_bits;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign legal = insn_legal(opc, f3, instr[31:25]);
  assign unused_bits = ^instr[24:15];

  alu_decoder u_alu_dec (
    .opc      (opc),
    .funct3   (f3),
    .alt      (instr[30]),
    .alu_mode (alu_mode)
  );

  // branch condition from datapath compare flags
  always_comb begin
    taken = 1'b0;
    unique case (f3)
      3'b000:  taken = br_EQ;
      3'b001:  taken = ~br_EQ;
      3'b100:  taken = br_LT;
      3'b101:  taken = ~br_LT;
      3'b110:  taken = br_LTU;
      3'b111:  taken = ~br_LTU;
      default: taken = 1'b0;
    endcase
  end

  // strobe decode and next state
  always_comb begin
    c        = '0;
    state_nx = state;
    unique case (state)
      ST_FETCH: begin
        c.addrs_sel = 1'b1;
        c.instr_en  = 1'b1;
        c.mem_in_en = 1'b1;
        state_nx    = ST_EXEC;
      end
      ST_EXEC: begin
        if (!legal) begin
          state_nx = ST_HALT;
        end else begin
          state_nx   = ST_FETCH;
          c.alu_mode = alu_mode;
          c.pc_en    = 1'b1;
          unique case (1'b1)
            opc == OPC_OP_IMM: begin
              c.rs2_sel = 1'b1;
              c.imm_sel = IMM_I;
              c.reg_sel = REG_SEL_ALU;
              c.reg_we  = 1'b1;
            end
            opc == OPC_OP: begin
              c.reg_sel = REG_SEL_ALU;
              c.reg_we  = 1'b1;
            end
            opc == OPC_LUI: begin
              c.imm_sel = IMM_U;
              c.reg_sel = REG_SEL_IMM;
              c.reg_we  = 1'b1;
            end
            opc == OPC_AUIPC: begin
              c.rs1_sel = 1'b1;
              c.rs2_sel = 1'b1;
              c.imm_sel = IMM_U;
              c.reg_sel = REG_SEL_ALU;
              c.reg_we  = 1'b1;
            end
            opc == OPC_JAL: begin
              c.imm_sel = IMM_J;
              c.reg_sel = REG_SEL_PC4;
              c.pc_sel  = PC_SEL_TGT;
              c.reg_we  = 1'b1;
            end
            opc == OPC_JALR: begin
              c.rs2_sel = 1'b1;
              c.imm_sel = IMM_I;
              c.reg_sel = REG_SEL_PC4;
              c.pc_sel  = PC_SEL_JALR;
              c.reg_we  = 1'b1;
            end
            opc == OPC_BRANCH: begin
              c.imm_sel = IMM_B;
              c.pc_sel  = taken ? PC_SEL_TGT
                                : PC_SEL_PC4;
            end
            opc == OPC_STORE: begin
              c.rs2_sel    = 1'b1;
              c.imm_sel    = IMM_S;
              c.alu_mem_en = 1'b1;
              c.mem_we     = 1'b1;
              c.mem_mode   = mem_mode_of(f3);
            end
            opc == OPC_LOAD: begin
              c.rs2_sel    = 1'b1;
              c.imm_sel    = IMM_I;
              c.alu_mem_en = 1'b1;
              c.mem_in_en  = 1'b1;
              c.mem_mode   = mem_mode_of(f3);
              c.pc_en      = 1'b0;
              state_nx     = ST_LOAD_WB;
            end
            default: begin
              c        = '0;
              state_nx = ST_HALT;
            end
          endcase
        end
      end
      ST_LOAD_WB: begin
        c.reg_sel  = REG_SEL_MEM;
        c.reg_we   = 1'b1;
        c.pc_sel   = PC_SEL_PC4;
        c.pc_en    = 1'b1;
        c.mem_mode = mem_mode_of(f3);
        state_nx   = ST_FETCH;
      end
      ST_HALT: begin
        state_nx = ST_HALT;
      end
      default: begin
        state_nx = ST_FETCH;
      end
    endcase
    if (instr[11:7] == 5'd0)
      c.reg_we = 1'b0;
  end

  // reset kills every strobe immediately
  assign o = reset ? c : '0;

  assign reg_WE     = o.reg_we;
  assign rs1_SEL    = o.rs1_sel;
  assign rs2_SEL    = o.rs2_sel;
  assign addrs_SEL  = o.addrs_sel;
  assign pc_EN      = o.pc_en;
  assign instr_EN   = o.instr_en;
  assign ALU_mem_EN = o.alu_mem_en;
  assign mem_in_EN  = o.mem_in_en;
  assign mem_WE     = o.mem_we;
  assign reg_SEL    = o.reg_sel;
  assign pc_SEL     = o.pc_sel;
  assign imm_SEL    = o.imm_sel;
  assign mem_MODE   = o.mem_mode;
  assign ALU_MODE   = o.alu_mode;
  assign halted     = reset && (state == ST_HALT);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_FETCH;
    else
      state <= state_nx;
  end

  // retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retire_CNT <= '0;
    else if (o.pc_en)
      retire_CNT <= retire_CNT + CNT_W'(1);
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit.
// Expected strobes queued per cycle, compared at negedge.
module tb_control_unit;

  typedef struct packed {
    logic       reg_we;
    logic       rs1_sel;
    logic       rs2_sel;
    logic       addrs_sel;
    logic       pc_en;
    logic       instr_en;
    logic       alu_mem_en;
    logic       mem_in_en;
    logic       mem_we;
    logic [1:0] reg_sel;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [2:0] mem_mode;
    logic [3:0] alu_mode;
    logic       halted;
  } obs_t;

  typedef struct {
    string       tag;
    obs_t        o;
    logic [31:0] cnt;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        br_EQ, br_LT, br_LTU;
  logic        reg_WE, rs1_SEL, rs2_SEL, addrs_SEL;
  logic        pc_EN, instr_EN, ALU_mem_EN;
  logic        mem_in_EN, mem_WE, halted;
  logic [1:0]  reg_SEL, pc_SEL;
  logic [2:0]  imm_SEL, mem_MODE;
  logic [3:0]  ALU_MODE;
  logic [31:0] retire_CNT;

  obs_t        obs;
  sb_t         q[$];
  sb_t         s;
  logic [31:0] exp_cnt;
  int          checks;
  int          failures;

  control_unit #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .br_EQ      (br_EQ),
    .br_LT      (br_LT),
    .br_LTU     (br_LTU),
    .reg_WE     (reg_WE),
    .rs1_SEL    (rs1_SEL),
    .rs2_SEL    (rs2_SEL),
    .addrs_SEL  (addrs_SEL),
    .pc_EN      (pc_EN),
    .instr_EN   (instr_EN),
    .ALU_mem_EN (ALU_mem_EN),
    .mem_in_EN  (mem_in_EN),
    .mem_WE     (mem_WE),
    .reg_SEL    (reg_SEL),
    .pc_SEL     (pc_SEL),
    .imm_SEL    (imm_SEL),
    .mem_MODE   (mem_MODE),
    .ALU_MODE   (ALU_MODE),
    .halted     (halted),
    .retire_CNT (retire_CNT)
  );

  assign obs = {reg_WE, rs1_SEL, rs2_SEL, addrs_SEL,
                pc_EN, instr_EN, ALU_mem_EN, mem_in_EN,
                mem_WE, reg_SEL, pc_SEL, imm_SEL,
                mem_MODE, ALU_MODE, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      s = q.pop_front();
      check({s.tag, ":out"}, 32'(obs), 32'(s.o));
      check({s.tag, ":cnt"}, retire_CNT, s.cnt);
    end
  end

  task automatic push(input string tag, input obs_t e);
    q.push_back('{tag: tag, o: e, cnt: exp_cnt});
    if (e.pc_en)
      exp_cnt = exp_cnt + 1;
  endtask

  localparam obs_t ZERO  = '{default: '0};
  localparam obs_t FETCH =
    '{addrs_sel: 1'b1, instr_en: 1'b1,
      mem_in_en: 1'b1, default: '0};
  localparam obs_t HALTP = '{halted: 1'b1, default: '0};

  task automatic insn(
    input string       tag,
    input logic [31:0] i,
    input logic        eq,
    input logic        lt,
    input logic        ltu,
    input obs_t        ex,
    input logic        ld,
    input obs_t        wb
  );
    @(posedge clk); #1;
    instr  = i;
    br_EQ  = 1'b0;
    br_LT  = 1'b0;
    br_LTU = 1'b0;
    push({tag, ".f"}, FETCH);
    @(posedge clk); #1;
    br_EQ  = eq;
    br_LT  = lt;
    br_LTU = ltu;
    push({tag, ".x"}, ex);
    if (ld) begin
      @(posedge clk); #1;
      push({tag, ".wb"}, wb);
    end
  endtask

  obs_t e_addi, e_add, e_sub, e_srai, e_addin;
  obs_t e_sw, e_lbu, e_lbuwb, e_br_t, e_br_n;
  obs_t e_add0, e_lui, e_jal, e_jalr;

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    reset    = 1'b0;
    instr    = 32'h0;
    br_EQ    = 1'b0;
    br_LT    = 1'b0;
    br_LTU   = 1'b0;

    e_addi = '{rs2_sel: 1'b1, imm_sel: 3'b011,
      reg_sel: 2'b01, reg_we: 1'b1, pc_en: 1'b1,
      default: '0};
    e_addin = e_addi;
    e_srai  = e_addi;
    e_srai.alu_mode = 4'b0111;
    e_add = '{reg_sel: 2'b01, reg_we: 1'b1,
      pc_en: 1'b1, default: '0};
    e_sub = e_add;
    e_sub.alu_mode = 4'b0001;
    e_add0 = e_add;
    e_add0.reg_we = 1'b0;
    e_sw = '{rs2_sel: 1'b1, imm_sel: 3'b001,
      alu_mem_en: 1'b1, mem_we: 1'b1, pc_en: 1'b1,
      default: '0};
    e_lbu = '{rs2_sel: 1'b1, imm_sel: 3'b011,
      alu_mem_en: 1'b1, mem_in_en: 1'b1,
      mem_mode: 3'b110, default: '0};
    e_lbuwb = '{reg_we: 1'b1, pc_en: 1'b1,
      mem_mode: 3'b110, default: '0};
    e_br_t = '{imm_sel: 3'b010, pc_en: 1'b1,
      pc_sel: 2'b01, default: '0};
    e_br_n = '{imm_sel: 3'b010, pc_en: 1'b1,
      default: '0};
    e_lui = '{imm_sel: 3'b100, reg_sel: 2'b11,
      reg_we: 1'b1, pc_en: 1'b1, default: '0};
    e_jal = '{imm_sel: 3'b101, reg_sel: 2'b10,
      pc_sel: 2'b01, reg_we: 1'b1, pc_en: 1'b1,
      default: '0};
    e_jalr = '{rs2_sel: 1'b1, imm_sel: 3'b011,
      reg_sel: 2'b10, pc_sel: 2'b10, reg_we: 1'b1,
      pc_en: 1'b1, default: '0};

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      push("rst", ZERO);
    end

    @(posedge clk); #1;
    instr = 32'h00800513;
    reset = 1'b1;
    push("addi.f", FETCH);
    @(posedge clk); #1;
    push("addi.x", e_addi);

    insn("add",  32'h00b505b3, 0, 0, 0, e_add,  0, ZERO);
    insn("sub",  32'h40b505b3, 0, 0, 0, e_sub,  0, ZERO);
    insn("srai", 32'h4032d293, 0, 0, 0, e_srai, 0, ZERO);
    insn("addin",32'hc0000293, 0, 0, 0, e_addin,0, ZERO);
    insn("add0", 32'h00b50033, 0, 0, 0, e_add0, 0, ZERO);
    insn("sw",   32'h00b52023, 0, 0, 0, e_sw,   0, ZERO);
    insn("lbu",  32'h00054283, 0, 0, 0, e_lbu,  1, e_lbuwb);
    insn("beqt", 32'h00000463, 1, 0, 0, e_br_t, 0, ZERO);
    insn("beqn", 32'h00000463, 0, 0, 0, e_br_n, 0, ZERO);
    insn("bnet", 32'h00001463, 0, 1, 1, e_br_t, 0, ZERO);
    insn("bget", 32'h00005463, 1, 0, 1, e_br_t, 0, ZERO);
    insn("bltu", 32'h00006463, 1, 1, 1, e_br_t, 0, ZERO);
    insn("lui",  32'h123452b7, 0, 0, 0, e_lui,  0, ZERO);
    insn("jal",  32'h000000ef, 0, 0, 0, e_jal,  0, ZERO);
    insn("jalr", 32'h000280e7, 0, 0, 0, e_jalr, 0, ZERO);
    insn("ecall",32'h00000073, 0, 0, 0, ZERO,   0, ZERO);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      push("halt", HALTP);
    end

    @(posedge clk); #1;
    reset   = 1'b0;
    exp_cnt = 0;
    push("rst2", ZERO);
    @(posedge clk); #1;
    push("rst2", ZERO);
    @(posedge clk); #1;
    instr = 32'h00800513;
    reset = 1'b1;
    push("addi2.f", FETCH);
    @(posedge clk); #1;
    push("addi2.x", e_addi);

    insn("mul", 32'h023100b3, 0, 0, 0, ZERO, 0, ZERO);
    @(posedge clk); #1;
    push("halt2", HALTP);

    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
